instr_mem_burst: RTL

//  Parametrised instruction memory for the vector processor: a 1W/1R synchronous array

---
 rtl/instr_mem_pkg.sv | 18 +
 rtl/instr_mem_array.sv | 33 +++
 rtl/instr_mem_burst.sv | 128 ++++++++++++
 3 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the burst-loaded instruction memory.
// Optional feature macro: INSTR_MEM_PARITY_EN (adds one even-parity bit per stored word).
package instr_mem_pkg;

  // Widest word the parity helper accepts; callers zero-extend, which leaves parity unchanged.
  localparam int PAR_MAX_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_e;

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// 1W/1R synchronous RAM with a registered, enable-gated read port.
// Width is set by the parent (DATA_W, plus one bit when INSTR_MEM_PARITY_EN is defined).
module instr_mem_array #(
  parameter int WIDTH  = 60,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array is deliberately left without reset so it maps onto RAM macros;
  // only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register only updates on an accepted read, so its value holds between fetches.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_burst.sv
// Instruction memory with a burst loader (base + length) and a 1-cycle-latency fetch port.
// Optional feature macro: INSTR_MEM_PARITY_EN (stored parity and sticky par_err).
module instr_mem_burst
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = 60,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [LEN_W-1:0]  ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              par_err
);

`ifdef INSTR_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  ld_state_e         state;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  cnt;
  logic              wr_en;
  logic              rd_en;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;

  assign fetch_ready = (state == IDLE);
  assign rd_en       = fetch_req & fetch_ready;
  // Reset wins over a word presented in the same cycle: an aborted burst writes nothing more.
  assign wr_en       = ld_valid & ld_ready & ~rst;

  // NOTE: all state here is sequential, so every assignment uses <= to avoid ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      ld_ready    <= 1'b0;
      ld_done     <= 1'b0;
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= rd_en;
      ld_done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ld_start) begin
            ptr <= ld_base;
            cnt <= ld_len;
            if (ld_len == '0) begin
              state   <= DONE;
              ld_done <= 1'b1;
            end else begin
              state    <= LOAD;
              ld_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (wr_en) begin
            ptr <= ptr + 1'b1;
            cnt <= cnt - 1'b1;
            if (cnt == LEN_W'(1)) begin
              state    <= DONE;
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: begin
          state    <= IDLE;
          ld_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef INSTR_MEM_PARITY_EN
  logic par_sticky;
  logic par_bad;

  assign wr_word = {even_parity(PAR_MAX_W'(ld_data)), ld_data};
  // Checked on the word being presented so the flag rises together with fetch_valid.
  assign par_bad = fetch_valid &
                   (even_parity(PAR_MAX_W'(rd_word[DATA_W-1:0])) != rd_word[DATA_W]);

  always_ff @(posedge clk) begin
    if (rst)          par_sticky <= 1'b0;
    else if (par_bad) par_sticky <= 1'b1;
  end

  assign par_err = par_sticky | par_bad;
`else
  assign wr_word = ld_data;
  assign par_err = 1'b0;
`endif

  instr_mem_array #(
    .WIDTH  (MEM_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (ptr),
    .wdata (wr_word),
    .re    (rd_en),
    .raddr (fetch_addr),
    .rdata (rd_word)
  );

  assign fetch_data = rd_word[DATA_W-1:0];

endmodule
